// File: rtl/uart_rx_ctrl_if.sv
// Bundles the config, receiver-side and host-side signals of uart_rx_ctrl.
// The master modport is the controller; the slave modport is its environment.
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cfg_wr;
  logic [5:0]    cfg_prescale;
  logic          cfg_par_en;
  logic          cfg_busy;
  logic          cfg_err;

  logic          rx_busy;
  logic [7:0]    rx_data;
  logic          rx_data_valid;
  logic          rx_par_err;
  logic          rx_stp_err;
  logic          rx_en;
  logic [5:0]    Prescale;
  logic          PAR_EN;

  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [CW-1:0] fifo_count;
  logic          overrun;
  logic [7:0]    par_err_cnt;
  logic [7:0]    stp_err_cnt;
  logic          clr_stats;

  modport master (
    input  cfg_wr, cfg_prescale, cfg_par_en,
    input  rx_busy, rx_data, rx_data_valid, rx_par_err, rx_stp_err,
    input  rd_ready, clr_stats,
    output cfg_busy, cfg_err, rx_en, Prescale, PAR_EN,
    output rd_data, rd_valid, fifo_count, overrun, par_err_cnt, stp_err_cnt
  );

  modport slave (
    output cfg_wr, cfg_prescale, cfg_par_en,
    output rx_busy, rx_data, rx_data_valid, rx_par_err, rx_stp_err,
    output rd_ready, clr_stats,
    input  cfg_busy, cfg_err, rx_en, Prescale, PAR_EN,
    input  rd_data, rd_valid, fifo_count, overrun, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver control: idle-only config commit (2 cycles when idle), show-ahead byte FIFO
// with zero-latency head, drop-and-flag on full without pop, saturating error statistics.
module uart_rx_ctrl #(
  parameter int         DEPTH        = 8,
  parameter logic [5:0] PRESCALE_RST = 6'd8,
  parameter logic       PAR_EN_RST   = 1'b0
) (
  input logic          clk,
  input logic          RST,
  uart_rx_ctrl_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, PEND, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [5:0]    shadow_ps_q;
  logic          shadow_pe_q;
  logic [5:0]    prescale_q;
  logic          par_en_q;
  logic          cfg_err_q;
  logic          rx_en_c;

  logic          cfg_legal, cfg_ok, cfg_bad, commit_load;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overrun_q;
  logic [7:0]    par_cnt_q, stp_cnt_q;
  logic          push_req, push, pop, full, empty;
  logic          par_inc, stp_inc;

  // ---------------- configuration ----------------
  assign cfg_legal   = bus.cfg_prescale inside {6'd8, 6'd16, 6'd32};
  assign cfg_ok      = bus.cfg_wr && cfg_legal;
  assign cfg_bad     = bus.cfg_wr && !cfg_legal;
  assign commit_load = (state_q == PEND) && !bus.rx_busy;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= RUN;
    else      state_q <= state_d;
  end

  // rx_en drops in the idle-detect cycle so no frame can start under the old settings
  always_comb begin
    state_d = state_q;
    rx_en_c = 1'b1;
    case (state_q)
      RUN: begin
        if (cfg_ok) state_d = PEND;
      end
      PEND: begin
        if (!bus.rx_busy) begin
          state_d = COMMIT;
          rx_en_c = 1'b0;
        end
      end
      COMMIT: begin
        rx_en_c = 1'b0;
        state_d = cfg_ok ? PEND : RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      shadow_ps_q <= PRESCALE_RST;
      shadow_pe_q <= PAR_EN_RST;
    end else if (cfg_ok) begin
      shadow_ps_q <= bus.cfg_prescale;
      shadow_pe_q <= bus.cfg_par_en;
    end
  end

  // A write landing in the commit-entry cycle is the newest, so it wins over the shadow
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      prescale_q <= PRESCALE_RST;
      par_en_q   <= PAR_EN_RST;
    end else if (commit_load) begin
      prescale_q <= cfg_ok ? bus.cfg_prescale : shadow_ps_q;
      par_en_q   <= cfg_ok ? bus.cfg_par_en   : shadow_pe_q;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST)               cfg_err_q <= 1'b0;
    else if (bus.clr_stats) cfg_err_q <= 1'b0;
    else if (cfg_bad)       cfg_err_q <= 1'b1;
  end

  // ---------------- byte FIFO ----------------
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push_req = bus.rx_data_valid && !bus.rx_stp_err && !(par_en_q && bus.rx_par_err);
  assign pop      = !empty && bus.rd_ready;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- statistics ----------------
  assign par_inc = bus.rx_data_valid && par_en_q && bus.rx_par_err;
  assign stp_inc = bus.rx_data_valid && bus.rx_stp_err;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      overrun_q <= 1'b0;
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else if (bus.clr_stats) begin
      overrun_q <= 1'b0;
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else begin
      if (push_req && full && !pop)        overrun_q <= 1'b1;
      if (par_inc && par_cnt_q != 8'hFF)   par_cnt_q <= par_cnt_q + 8'd1;
      if (stp_inc && stp_cnt_q != 8'hFF)   stp_cnt_q <= stp_cnt_q + 8'd1;
    end
  end

  assign bus.cfg_busy    = (state_q != RUN);
  assign bus.cfg_err     = cfg_err_q;
  assign bus.rx_en       = rx_en_c;
  assign bus.Prescale    = prescale_q;
  assign bus.PAR_EN      = par_en_q;
  assign bus.rd_data     = mem[rd_ptr_q];
  assign bus.rd_valid    = !empty;
  assign bus.fifo_count  = count_q;
  assign bus.overrun     = overrun_q;
  assign bus.par_err_cnt = par_cnt_q;
  assign bus.stp_err_cnt = stp_cnt_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: config vector table, directed FIFO/statistics sequences,
// then random receiver traffic against a queue-based reference model.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic RST = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_ctrl #(
    .DEPTH(DEPTH),
    .PRESCALE_RST(6'd8),
    .PAR_EN_RST(1'b0)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [5:0] ps;
    logic       pe;
    logic       busy;
    logic       clr;
    logic [5:0] e_ps;
    logic       e_pe;
    logic       e_rx_en;
    logic       e_cbusy;
    logic       e_cerr;
  } cfg_vec_t;

  cfg_vec_t tbl[$];

  function automatic cfg_vec_t cv(input logic wr, input int ps, input logic pe,
                                  input logic busy, input logic clr, input int e_ps,
                                  input logic e_pe, input logic e_rx_en,
                                  input logic e_cbusy, input logic e_cerr);
    cfg_vec_t v;
    v.wr = wr; v.ps = 6'(ps); v.pe = pe; v.busy = busy; v.clr = clr;
    v.e_ps = 6'(e_ps); v.e_pe = e_pe; v.e_rx_en = e_rx_en;
    v.e_cbusy = e_cbusy; v.e_cerr = e_cerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_wr = 1'b0; bus.cfg_prescale = 6'd8; bus.cfg_par_en = 1'b0;
    bus.rx_busy = 1'b0; bus.rx_data = 8'h00; bus.rx_data_valid = 1'b0;
    bus.rx_par_err = 1'b0; bus.rx_stp_err = 1'b0;
    bus.rd_ready = 1'b0; bus.clr_stats = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b1;
  endtask

  task automatic rx_cycle(input logic dv, input logic [7:0] d, input logic pe,
                          input logic se, input logic rdy);
    bus.rx_data_valid = dv; bus.rx_data = d; bus.rx_par_err = pe;
    bus.rx_stp_err = se; bus.rd_ready = rdy;
    cyc();
    bus.rx_data_valid = 1'b0; bus.rx_par_err = 1'b0;
    bus.rx_stp_err = 1'b0; bus.rd_ready = 1'b0;
  endtask

  task automatic cfg_write(input logic [5:0] ps, input logic pe);
    bus.rx_busy = 1'b0;
    bus.cfg_wr = 1'b1; bus.cfg_prescale = ps; bus.cfg_par_en = pe;
    cyc();
    bus.cfg_wr = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!bus.cfg_busy) break;
      cyc();
    end
    chk("cfg_commit_done", bus.cfg_busy, 0);
    chk("cfg_commit_ps", bus.Prescale, ps);
  endtask

  // Reference model state
  logic [7:0] mq[$];
  int  m_par, m_stp;
  bit  m_ov, m_pe;

  task automatic model_step(input bit dv, input bit par, input bit stp, input bit rdy,
                            input bit clr, input logic [7:0] d);
    bit push_req, pop, full;
    push_req = dv && !stp && !(m_pe && par);
    pop      = (mq.size() > 0) && rdy;
    full     = (mq.size() == DEPTH);
    if (clr) m_ov = 0; else if (push_req && full && !pop) m_ov = 1;
    if (clr) m_par = 0; else if (dv && m_pe && par) m_par = (m_par < 255) ? m_par + 1 : 255;
    if (clr) m_stp = 0; else if (dv && stp) m_stp = (m_stp < 255) ? m_stp + 1 : 255;
    if (pop) void'(mq.pop_front());
    if (push_req && (!full || pop)) mq.push_back(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];

    do_reset();
    chk("rst_prescale", bus.Prescale, 8);
    chk("rst_par_en", bus.PAR_EN, 0);
    chk("rst_rx_en", bus.rx_en, 1);
    chk("rst_cfg_busy", bus.cfg_busy, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_par_cnt", bus.par_err_cnt, 0);
    chk("rst_stp_cnt", bus.stp_err_cnt, 0);

    //          wr ps  pe busy clr | ps pe rx_en cbusy cerr
    tbl.push_back(cv(1, 32, 1, 0, 0,   8, 0, 1, 0, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,   8, 0, 0, 1, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,  32, 1, 0, 1, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,  32, 1, 1, 0, 0));
    tbl.push_back(cv(1, 12, 0, 0, 0,  32, 1, 1, 0, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,  32, 1, 1, 0, 1));
    tbl.push_back(cv(0,  8, 0, 0, 1,  32, 1, 1, 0, 1));
    tbl.push_back(cv(0,  8, 0, 0, 0,  32, 1, 1, 0, 0));
    tbl.push_back(cv(1, 16, 0, 0, 0,  32, 1, 1, 0, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,  32, 1, 0, 1, 0));
    tbl.push_back(cv(1,  8, 1, 0, 0,  16, 0, 0, 1, 0));
    tbl.push_back(cv(0,  8, 0, 1, 0,  16, 0, 1, 1, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,  16, 0, 0, 1, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,   8, 1, 0, 1, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,   8, 1, 1, 0, 0));
    tbl.push_back(cv(1, 40, 0, 0, 1,   8, 1, 1, 0, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,   8, 1, 1, 0, 0));
    tbl.push_back(cv(1, 32, 0, 0, 0,   8, 1, 1, 0, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,   8, 1, 0, 1, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,  32, 0, 0, 1, 0));
    tbl.push_back(cv(0,  8, 0, 0, 0,  32, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      bus.cfg_wr = tbl[i].wr; bus.cfg_prescale = tbl[i].ps; bus.cfg_par_en = tbl[i].pe;
      bus.rx_busy = tbl[i].busy; bus.clr_stats = tbl[i].clr;
      #1;
      chk($sformatf("vec%0d_prescale", i), bus.Prescale, tbl[i].e_ps);
      chk($sformatf("vec%0d_par_en", i), bus.PAR_EN, tbl[i].e_pe);
      chk($sformatf("vec%0d_rx_en", i), bus.rx_en, tbl[i].e_rx_en);
      chk($sformatf("vec%0d_cfg_busy", i), bus.cfg_busy, tbl[i].e_cbusy);
      chk($sformatf("vec%0d_cfg_err", i), bus.cfg_err, tbl[i].e_cerr);
      cyc();
    end
    idle_inputs();

    // Long busy receiver: commit deferred, last write (8,1) wins
    for (int i = 0; i < 50; i++) begin
      bus.rx_busy = 1'b1;
      bus.cfg_wr = (i == 0) || (i == 20);
      bus.cfg_prescale = (i == 0) ? 6'd16 : 6'd8;
      bus.cfg_par_en = (i != 0);
      #1;
      chk("busy_prescale_held", bus.Prescale, 32);
      chk("busy_rx_en", bus.rx_en, 1);
      if (i > 0) chk("busy_cfg_busy", bus.cfg_busy, 1);
      cyc();
    end
    bus.cfg_wr = 1'b0; bus.rx_busy = 1'b0;
    #1;
    chk("fall_rx_en", bus.rx_en, 0);
    chk("fall_prescale", bus.Prescale, 32);
    cyc();
    #1;
    chk("commit_prescale", bus.Prescale, 8);
    chk("commit_par_en", bus.PAR_EN, 1);
    chk("commit_rx_en", bus.rx_en, 0);
    cyc();
    #1;
    chk("run_rx_en", bus.rx_en, 1);
    chk("run_cfg_busy", bus.cfg_busy, 0);
    cyc();

    // Overfill: 9 pushes into 8 entries
    for (int i = 1; i <= 9; i++) rx_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    #1;
    chk("ovf_count", bus.fifo_count, 8);
    chk("ovf_overrun", bus.overrun, 1);
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("ovf_pop_data", bus.rd_data, i);
      rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    #1;
    chk("drained_valid", bus.rd_valid, 0);
    rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    chk("empty_pop_count", bus.fifo_count, 0);
    bus.clr_stats = 1'b1;
    cyc();
    bus.clr_stats = 1'b0;
    #1;
    chk("clr_overrun", bus.overrun, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) rx_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    rx_cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    #1;
    chk("fullpp_count", bus.fifo_count, 8);
    chk("fullpp_overrun", bus.overrun, 0);
    exp_q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
    foreach (exp_q[i]) begin
      #1;
      chk("fullpp_pop_data", bus.rd_data, exp_q[i]);
      rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end

    // Saturation with PAR_EN=1, all frames bad
    for (int i = 0; i < 300; i++) rx_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
    #1;
    chk("sat_par_cnt", bus.par_err_cnt, 255);
    chk("sat_stp_cnt", bus.stp_err_cnt, 255);
    chk("sat_fifo_count", bus.fifo_count, 0);
    bus.clr_stats = 1'b1;
    rx_cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    bus.clr_stats = 1'b0;
    #1;
    chk("clr_wins_par", bus.par_err_cnt, 0);
    chk("clr_wins_stp", bus.stp_err_cnt, 0);

    // PAR_EN=0: parity-flagged bytes are good and not counted
    cfg_write(6'd8, 1'b0);
    for (int i = 0; i < 4; i++) rx_cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
    #1;
    chk("nopar_count", bus.fifo_count, 4);
    chk("nopar_par_cnt", bus.par_err_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nopar_data", bus.rd_data, 8'h60 + i);
      rx_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end

    // Random traffic against the reference model
    do_reset();
    mq.delete(); m_par = 0; m_stp = 0; m_ov = 0; m_pe = 0;
    for (int burst = 0; burst < 2; burst++) begin
      if (burst == 1) begin
        cfg_write(6'd16, 1'b1);
        m_pe = 1;
      end
      for (int n = 0; n < 400; n++) begin
        bit dv, par, stp, rdy, clr;
        logic [7:0] d;
        dv  = ($urandom_range(0, 1) == 0);
        par = ($urandom_range(0, 3) == 0);
        stp = ($urandom_range(0, 4) == 0);
        rdy = ($urandom_range(0, 4) < 2);
        clr = ($urandom_range(0, 63) == 0);
        d   = 8'($urandom_range(0, 255));
        bus.rx_data_valid = dv; bus.rx_par_err = par; bus.rx_stp_err = stp;
        bus.rd_ready = rdy; bus.clr_stats = clr; bus.rx_data = d;
        bus.rx_busy = 1'($urandom_range(0, 1));
        #1;
        chk("rnd_rd_valid", bus.rd_valid, (mq.size() > 0));
        chk("rnd_count", bus.fifo_count, mq.size());
        if (mq.size() > 0) chk("rnd_rd_data", bus.rd_data, mq[0]);
        chk("rnd_overrun", bus.overrun, m_ov);
        chk("rnd_par_cnt", bus.par_err_cnt, m_par);
        chk("rnd_stp_cnt", bus.stp_err_cnt, m_stp);
        model_step(dv, par, stp, rdy, clr, d);
        cyc();
      end
      idle_inputs();
    end

    // Reset mid-operation discards stored bytes
    for (int i = 0; i < 3; i++) rx_cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_rd_valid", bus.rd_valid, 0);
    chk("arst_par_en", bus.PAR_EN, 0);
    cyc();
    RST = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
